// File: rtl/serial_add_collector.sv
// Bit-serial LSB-first adder: a carry register chains beats into a full add,
// and sum bits are gathered into a word handed off under valid/ready.
module serial_add_collector #(
   parameter int WIDTH = 8,
   localparam int CW = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_a,
   input  logic             in_b,
   input  logic             in_last,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic [CW-1:0]    out_bits
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [CW-1:0] WMAX = CW'(WIDTH);

   state_t           state_q, state_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;

   logic             accept;
   logic             s_bit;
   logic             c_next;

   always_comb begin
      state_d  = state_q;
      carry_d  = carry_q;
      sum_d    = sum_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      in_ready = (state_q != HOLD);
      accept   = in_valid & in_ready;
      s_bit    = in_a ^ in_b ^ carry_q;
      c_next   = (in_a & in_b) | (carry_q & (in_a ^ in_b));

      unique case (state_q)
         IDLE, ACCUM: begin
            if (accept) begin
               carry_d = c_next;
               // Beats past WIDTH only feed the carry and flag overflow
               if (count_q < WMAX) begin
                  sum_d   = sum_q | ({{(WIDTH-1){1'b0}}, s_bit} << count_q);
                  count_d = count_q + 1'b1;
               end else begin
                  ovf_d = 1'b1;
               end
               state_d = in_last ? HOLD : ACCUM;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
               carry_d = 1'b0;
               sum_d   = '0;
               count_d = '0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         carry_q <= 1'b0;
         sum_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out_valid = (state_q == HOLD);
   assign out_sum   = sum_q;
   assign out_cout  = carry_q;
   assign out_ovf   = ovf_q;
   assign out_bits  = count_q;

endmodule
